// File: rtl/ringosc_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ringosc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } meas_state_t;

  localparam int SYNC_STAGES  = 2;
  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W_DEF    = 16;
  localparam int GATE_W_DEF   = 16;

endpackage

// File: rtl/ringosc_edge_sync.sv
// Synchronizes the free-running ring output into clk and flags its rising edges.
module ringosc_edge_sync
  import ringosc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  // sh[0..SYNC_STAGES-1] is the synchronizer; the extra top flop holds the previous value.
  logic [SYNC_STAGES:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[SYNC_STAGES-1:0], async_in};
  end

  assign edge_pulse = sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement controller: enable, settle, count edges over a gate, hand back result.
// Define RINGOSC_MEAS_CONTINUOUS_EN to keep the ring running and chain back-to-back windows.
module ringosc_meas_ctrl
  import ringosc_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_W        = GATE_W_DEF,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              osc_en,
  input  logic              osc_in,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow
);

  // One down-counter times every phase, so it must hold the largest of them.
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W0 = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam int TMR_W  = (TMR_W0 > 2) ? TMR_W0 : 2;

  meas_state_t       state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_d, osc_en_d, vld_d, busy_d;
  logic              edge_pulse;

  ringosc_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (osc_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    gate_d  = gate_q;
    cnt_d   = result;
    ovf_d   = overflow;
    case (state_q)
      ST_IDLE: begin
        if (start && (gate_len != '0)) begin
          state_d = ST_SETTLE;
          gate_d  = gate_len;
          tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = ST_GATE;
          tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_GATE: begin
        // Saturate rather than wrap; overflow marks that an edge was lost.
        if (edge_pulse) begin
          if (&result) ovf_d = 1'b1;
          else         cnt_d = result + CNT_W'(1);
        end
        if (tmr_q == '0) begin
          state_d = ST_DRAIN;
          tmr_d   = TMR_W'(DRAIN_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (tmr_q == '0) state_d = ST_DONE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_DONE: begin
        if (result_ready) begin
`ifdef RINGOSC_MEAS_CONTINUOUS_EN
          if (start) begin
            state_d = ST_GATE;
            tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef RINGOSC_MEAS_CONTINUOUS_EN
    osc_en_d = (state_d != ST_IDLE);
`else
    osc_en_d = (state_d == ST_SETTLE) || (state_d == ST_GATE);
`endif
    vld_d  = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      gate_q       <= '0;
      result       <= '0;
      overflow     <= 1'b0;
      osc_en       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      gate_q       <= gate_d;
      result       <= cnt_d;
      overflow     <= ovf_d;
      osc_en       <= osc_en_d;
      busy         <= busy_d;
      result_valid <= vld_d;
    end
  end

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Bench for ringosc_meas_ctrl: timeline/window model plus directed literal checks and random traffic.
module tb_ringosc_meas_ctrl;

  localparam int S    = 8;
  localparam int CW   = 16;
  localparam int CWS  = 4;
  localparam int GW   = 16;
  localparam int MAXC = 40000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          osc_in = 1'b0;
  logic          result_ready = 1'b0;
  logic [GW-1:0] gate_len = '0;

  logic           osc_en, busy, result_valid, overflow;
  logic [CW-1:0]  result;
  logic           osc_en_s, busy_s, rv_s, ovf_s;
  logic [CWS-1:0] result_s;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ringosc_meas_ctrl #(.CNT_W(CW), .GATE_W(GW), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .osc_en(osc_en),
    .osc_in(osc_in), .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overflow(overflow)
  );

  // Narrow-counter copy on the same inputs exercises saturation.
  ringosc_meas_ctrl #(.CNT_W(CWS), .GATE_W(GW), .SETTLE_CYCLES(S)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .osc_en(osc_en_s),
    .osc_in(osc_in), .busy(busy_s), .result(result_s), .result_valid(rv_s),
    .result_ready(result_ready), .overflow(ovf_s)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc - 1);
  endtask

  // Oscillator source: mode 0 hold, 1 square wave toggling every osc_half cycles, 2 random.
  int osc_mode = 0;
  int osc_half = 2;
  int ph = 0;
  always @(negedge clk) begin
    if (osc_mode == 1) begin
      ph++;
      if (ph >= osc_half) begin ph = 0; osc_in = ~osc_in; end
    end else if (osc_mode == 2) begin
      osc_in = ($urandom_range(0, 1) == 1);
    end
  end

  // Model: one measurement is a timeline anchored at the accepting edge p.
  // After edge e: osc_en for e in [p, p+S+g-1], result_valid from p+S+g+2 until handshake.
  // An input rise first sampled at edge j is seen by the counter two edges later, so it
  // lands in the window when j is in [p+S-1, p+S+g-2].
  bit hist [MAXC];
  bit m_act = 1'b0;
  int m_p = 0, m_g = 0, m_cnt = 0;

  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++)
      if (hist[j] && !hist[j-1]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    int e;
    bit exp_osc, exp_rv;
    int exp_s;
    e = cyc;
    cyc = cyc + 1;
    if (e < MAXC) hist[e] = osc_in;
    if (!rst_n) begin
      m_act = 1'b0;
      m_cnt = 0;
    end else if (!m_act) begin
      if (start && gate_len != '0) begin
        m_act = 1'b1; m_p = e; m_g = int'(gate_len); m_cnt = 0;
      end
    end else if ((e - 1 >= m_p + S + m_g + 2) && result_ready) begin
      m_act = 1'b0;
    end
    if (m_act && e == m_p + S + m_g + 2) m_cnt = count_rises(m_p + S - 1, m_p + S + m_g - 2);
    exp_osc = m_act && (e - m_p < S + m_g);
    exp_rv  = m_act && (e >= m_p + S + m_g + 2);
    exp_s   = (m_cnt > 15) ? 15 : m_cnt;
    #1;
    chk("busy", busy, m_act);
    chk("osc_en", osc_en, exp_osc);
    chk("result_valid", result_valid, exp_rv);
    chk("busy_sat", busy_s, m_act);
    chk("osc_en_sat", osc_en_s, exp_osc);
    chk("result_valid_sat", rv_s, exp_rv);
    if (!m_act || exp_rv) begin
      chk("result", result, m_cnt);
      chk("overflow", overflow, 0);
      chk("result_sat", result_s, exp_s);
      chk("overflow_sat", ovf_s, (m_cnt > 15) ? 1 : 0);
    end
  end

  task automatic wait_rv(input string nm, input int budget);
    int n = 0;
    while (!result_valid && n < budget) begin @(negedge clk); n++; end
    chk(nm, result_valid, 1);
  endtask

  task automatic measure(input string nm, input int g);
    @(negedge clk);
    start = 1'b1; gate_len = GW'(g);
    @(negedge clk);
    start = 1'b0;
    wait_rv(nm, g + S + 20);
  endtask

  task automatic set_square(input int half);
    osc_mode = 1; osc_half = half; ph = 0;
  endtask

  initial begin
    int k, le, t_on, t_off, t_rv;

    // Reset
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_osc_en", osc_en, 0);
    chk("reset_result", result, 0);
    chk("reset_rv", result_valid, 0);
    rst_n = 1'b1;
    result_ready = 1'b1;

    // Basic count: period-4 input over 100 cycles
    set_square(2);
    repeat (4) @(negedge clk);
    measure("basic_timeout", 100);
    chk("basic_result", result, 25);
    chk("basic_overflow", overflow, 0);
    chk("basic_model", m_cnt, 25);
    @(negedge clk);

    // Latency: k is the cycle in which start is presented
    @(negedge clk);
    start = 1'b1; gate_len = GW'(10);
    k = cyc - 1;
    t_on = -1; t_off = -1; t_rv = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      le = cyc - 1;
      if (osc_en && t_on < 0) t_on = le;
      if (!osc_en && t_on >= 0 && t_off < 0) t_off = le;
      if (result_valid && t_rv < 0) t_rv = le;
    end
    chk("lat_osc_on", t_on - k, 1);
    chk("lat_osc_off", t_off - k, 19);
    chk("lat_rv", t_rv - k, 21);

    // Saturation: input toggles every cycle, 20 rises in a 40-cycle window
    set_square(1);
    repeat (4) @(negedge clk);
    measure("sat_timeout", 40);
    chk("sat_result4", result_s, 15);
    chk("sat_overflow4", ovf_s, 1);
    chk("sat_result16", result, 20);
    chk("sat_model", m_cnt, 20);
    @(negedge clk);

    // Zero window is rejected
    @(negedge clk);
    start = 1'b1; gate_len = '0;
    repeat (3) begin
      @(negedge clk);
      chk("zero_busy", busy, 0);
      chk("zero_osc_en", osc_en, 0);
    end
    start = 1'b0;

    // Start pulses while busy do not restart or alter the window
    set_square(2);
    repeat (4) @(negedge clk);
    start = 1'b1; gate_len = GW'(60);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; gate_len = GW'(7);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rv("busy_rej_timeout", 100);
    chk("busy_rej_result", result, 15);
    @(negedge clk);

    // Backpressure
    result_ready = 1'b0;
    measure("bp_timeout", 20);
    repeat (50) begin
      @(negedge clk);
      chk("bp_rv_held", result_valid, 1);
      chk("bp_result_held", result, 5);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_rv", result_valid, 0);

    // Reset mid-GATE, then a clean measurement
    @(negedge clk);
    start = 1'b1; gate_len = GW'(200);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_osc_en", osc_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_rv", result_valid, 0);
    repeat (3) @(negedge clk);
    measure("post_rst_timeout", 100);
    chk("post_rst_result", result, 25);
    @(negedge clk);

    // Random traffic against the model
    osc_mode = 2;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i % 1000 == 500) set_square($urandom_range(1, 3));
      else if (i % 1000 == 0) osc_mode = 2;
      start        = ($urandom_range(0, 3) == 0);
      gate_len     = ($urandom_range(0, 9) == 0) ? GW'(0) : GW'($urandom_range(1, 80));
      result_ready = ($urandom_range(0, 1) == 1);
      rst_n        = ($urandom_range(0, 699) != 0);
    end
    rst_n = 1'b1; start = 1'b0; result_ready = 1'b1;
    repeat (150) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
